md_result_stage: RTL
====================

Name: md_result_stage

Overview:
- EX-stage result unit for the pipelined MIPS core.
- Combines the multiply/divide engine (HI/LO registers, multi-cycle busy) with the EX result select among ALU, immediate, link address and HI/LO.
- Replaces the fixed 32-bit combinational result select with a parametrised block that generates its own stall request.
- Sits between the EX operand muxes and the EX/MEM pipeline register.

Parameters:
- W, 32, datapath width; HI/LO are W bits each.
- MUL_LAT, 5, cycles busy for mult/multu (>=1).
- DIV_LAT, 10, cycles busy for div/divu (>=1).
- PC_OFFSET, 8, added to pc for link result.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- md_start  input  1  start mult/div this cycle
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu
- mthi  input  1  write HI from src_a
- mtlo  input  1  write LO from src_a
- md_req  input  1  EX instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo)
- src_a  input  W  rs operand
- src_b  input  W  rt operand
- alu_out  input  W  ALU result
- imm  input  W  extended immediate (lui etc.)
- pc  input  W  EX instruction PC
- res_sel  input  2  00 alu_out, 01 imm, 10 pc+PC_OFFSET, 11 HI/LO
- rd_hi  input  1  when res_sel=11: 1 selects HI, 0 selects LO
- result  output  W  EX result
- busy  output  1  MD operation in flight
- md_stall  output  1  stall request to hazard unit
- hi, lo  output  W  architectural HI/LO

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, latched operands cleared, pending op discarded. md_stall and result are combinational from reset state.
- Two states, IDLE and BUSY.
- IDLE + md_start:
  - latch src_a, src_b, md_op;
  - load counter with MUL_LAT or DIV_LAT;
  - enter BUSY next edge, so busy=1 from the cycle after start.
- BUSY:
  - counter decrements every cycle.
  - On the edge where counter goes 1->0: commit HI/LO, return to IDLE, busy=0 on that same edge.
  - Total busy cycles = LAT exactly.
- Arithmetic is on latched operands. Result may be computed at start or at commit; only the commit timing is observable.
  - mult: signed 2W-bit product, HI=upper W, LO=lower W.
  - multu: same, unsigned.
  - div/divu: LO=quotient, HI=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: operation runs full DIV_LAT, HI/LO left unchanged.
  - Signed overflow (min / -1): LO=min value, HI=0.
- mthi/mtlo:
  - In IDLE without md_start: write src_a on the next edge. mthi and mtlo together write both.
  - In BUSY, or in the same cycle as md_start: ignored. md_start wins.
- md_start while busy: ignored. The hazard unit holds the instruction via md_stall.
- md_stall = md_req & busy (combinational). md_start with md_req in IDLE does not stall.
- Result select is combinational with no priority (one-hot decode of res_sel):
  - 10 gives pc+PC_OFFSET modulo 2^W.
  - 11 reads the current HI/LO registers. No forwarding of an in-flight result; md_stall prevents the hazard.
- hi, lo outputs reflect the registers directly.

Optional Feature:
- Macro MD_CANCEL_EN.
- Defined:
  - Adds input md_cancel (1 bit), used for exception/interrupt flush.
  - md_cancel=1 in BUSY: return to IDLE next edge, busy=0, HI/LO keep pre-start values.
  - md_cancel=1 together with md_start in IDLE: start suppressed.
  - md_cancel has no effect on mthi/mtlo.
- Not defined: port absent; every accepted operation completes.

Test Plan:
- Reset then res_sel=00/01/10 with alu_out=0x11, imm=0xABCD0000, pc=0x3000 -> result 0x11, 0xABCD0000, 0x3008; hi=lo=0.
- mult src_a=0xFFFFFFFF, src_b=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=1, LO=0xFFFFFFFE.
- div src_a=-7, src_b=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> HI/LO unchanged after 10 cycles.
- md_req=1 mflo issued one cycle after mult start -> md_stall=1 for all busy cycles; result (res_sel=11, rd_hi=0) equals the new LO once stall drops.
- mthi src_a=0x5 in IDLE -> hi=5 next cycle. mtlo during BUSY, or mtlo together with md_start -> LO not written by the mtlo.
- reset_n pulsed low mid-div -> busy=0, hi=lo=0 immediately. With MD_CANCEL_EN, md_cancel on cycle 3 of a mult -> busy=0 next edge, HI/LO keep old values.

Source files
------------

// File: rtl/md_result_stage.sv
// EX-stage result unit: multi-cycle mult/div engine with HI/LO, EX result select and MD stall request.
// Optional flush input md_cancel is present when MD_CANCEL_EN is defined.
module md_result_stage #(
  parameter int W         = 32,
  parameter int MUL_LAT   = 5,
  parameter int DIV_LAT   = 10,
  parameter int PC_OFFSET = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         md_start,
`ifdef MD_CANCEL_EN
  input  logic         md_cancel,
`endif
  input  logic [1:0]   md_op,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic         md_req,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic [W-1:0] alu_out,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] pc,
  input  logic [1:0]   res_sel,
  input  logic         rd_hi,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         md_stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] PC_OFF = W'(PC_OFFSET);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a, r_b, r_hi, r_lo;
  logic [1:0]       r_op;
  logic             w_start, w_commit, w_cancel;
  logic [W-1:0]     w_hi_nxt, w_lo_nxt;

`ifdef MD_CANCEL_EN
  assign w_cancel = md_cancel;
`else
  assign w_cancel = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: if (md_start && !w_cancel) begin
        w_start     = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: if (w_cancel) begin
        w_state_nxt = IDLE;
      end else if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = IDLE;
        w_commit    = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arithmetic on latched operands; divisor forced to 1 when the result is discarded or special-cased
  logic signed [2*W-1:0] w_prod_s;
  logic        [2*W-1:0] w_prod_u;
  logic signed [W-1:0]   w_sa, w_sb, w_sq, w_sr;
  logic        [W-1:0]   w_ub, w_uq, w_ur;
  logic                  w_b_zero, w_ovf;

  assign w_prod_s = $signed({{W{r_a[W-1]}}, r_a}) * $signed({{W{r_b[W-1]}}, r_b});
  assign w_prod_u = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
  assign w_b_zero = (r_b == '0);
  assign w_ovf    = (r_a == MIN_V) && (r_b == '1);
  assign w_sa     = r_a;
  assign w_sb     = (w_b_zero || w_ovf) ? W'(1) : r_b;
  assign w_sq     = w_sa / w_sb;
  assign w_sr     = w_sa % w_sb;
  assign w_ub     = w_b_zero ? W'(1) : r_b;
  assign w_uq     = r_a / w_ub;
  assign w_ur     = r_a % w_ub;

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    case (r_op)
      2'b00: {w_hi_nxt, w_lo_nxt} = w_prod_s;
      2'b01: {w_hi_nxt, w_lo_nxt} = w_prod_u;
      2'b10: begin
        if (w_ovf) begin
          w_hi_nxt = '0;
          w_lo_nxt = MIN_V;
        end else if (!w_b_zero) begin
          w_hi_nxt = w_sr;
          w_lo_nxt = w_sq;
        end
      end
      default: begin
        if (!w_b_zero) begin
          w_hi_nxt = w_ur;
          w_lo_nxt = w_uq;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_start) begin
        r_a   <= src_a;
        r_b   <= src_b;
        r_op  <= md_op;
        r_cnt <= md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (r_state == BUSY) begin
        r_cnt <= w_cancel ? '0 : r_cnt - CNT_W'(1);
      end
      // A raw md_start blocks mthi/mtlo even when a cancel suppresses the start
      if (w_commit) begin
        r_hi <= w_hi_nxt;
        r_lo <= w_lo_nxt;
      end else if (r_state == IDLE && !md_start) begin
        if (mthi) r_hi <= src_a;
        if (mtlo) r_lo <= src_a;
      end
    end
  end

  assign busy     = (r_state == BUSY);
  assign md_stall = md_req & busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  always_comb begin
    result = '0;
    case (res_sel)
      2'b00:   result = alu_out;
      2'b01:   result = imm;
      2'b10:   result = pc + PC_OFF;
      default: result = rd_hi ? r_hi : r_lo;
    endcase
  end

endmodule
